pe16_ctrl: RTL and testbench

PE16_CTRL -- requirements
Module: pe16_ctrl

---
 rtl/pe16_ctrl.sv | 111 +++++++++++
 tb/tb_pe16_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pe16_ctrl.sv
// pe16_ctrl: sequencing controller for one radix-2^2 SDF FFT stage.
// It tracks the sample index, issues butterfly/-j selects one cycle ahead
// of the data, advances the delay FIFO, tags stage outputs, and runs a
// SPAN-cycle drain that pushes out the FIFO contents after the last frame.
module pe16_ctrl #(
   parameter int IDX_W = 6,
   parameter int SPAN  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   input  logic in_first,
   input  logic flush,
   output logic s0,
   output logic s1,
   output logic w_en,
   output logic r_en,
   output logic out_valid,
   output logic out_first,
   output logic busy,
   output logic err
);

   localparam int CNT_W = IDX_W - 2;
   localparam logic [IDX_W-1:0] SPAN_IDX = IDX_W'(SPAN);

   typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx, nxt;
   logic [CNT_W-1:0]   cnt;
   logic               primed;
   logic               acc, drain_go, drain_done, err_ev;
   logic [1:0]         quad;
   // tag = {valid, first}; stage 1 and stage 2 of the output delay
   logic [1:0]         tag, p1, p2;

   // State register for the idle/drain controller
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state, selects, output tag and protocol-error detection
   always_comb begin
      state_nxt  = state;
      s0         = 1'b0;
      s1         = 1'b0;
      busy       = (state == ST_DRAIN);
      nxt        = in_first ? '0 : idx;
      quad       = nxt[IDX_W-1:IDX_W-2];
      acc        = in_valid & (state == ST_IDLE);
      drain_go   = flush & ~in_valid & (state == ST_IDLE) & primed;
      drain_done = (state == ST_DRAIN) & (cnt == '1);
      tag        = 2'b00;

      case (state)
         ST_IDLE:  if (drain_go)   state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_done) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase

      // Drain feeds zeros through the -j path; reset suppresses it
      if (state == ST_DRAIN) begin
         s1  = ~rst;
         tag = 2'b10;
      end else if (acc) begin
         s0  = nxt[IDX_W-2];
         s1  = (quad == 2'b00) & primed;
         // first frame: nothing meaningful leaves the stage until index SPAN
         tag = {(quad != 2'b00) | primed, nxt == SPAN_IDX};
      end

      err_ev = (flush & (in_valid | busy | ~primed))
             | (in_valid & busy)
             | (acc & in_first & (idx != '0));
   end

   // Index/primed tracking, drain counter, FIFO strobe and output pipe
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         primed <= 1'b0;
         cnt    <= '0;
         err    <= 1'b0;
         w_en   <= 1'b0;
         p1     <= '0;
         p2     <= '0;
      end else begin
         w_en <= in_valid | busy;
         p1   <= tag;
         p2   <= p1;
         if (err_ev) err <= 1'b1;
         if (acc) begin
            idx <= nxt + 1'b1;
            if (nxt == SPAN_IDX) primed <= 1'b1;
         end
         if (drain_go) cnt <= '0;
         else if (busy) cnt <= cnt + 1'b1;
         if (drain_done) begin
            primed <= 1'b0;
            idx    <= '0;
         end
      end
   end

   assign r_en      = w_en;
   assign out_valid = p2[1];
   assign out_first = p2[1] & p2[0];

endmodule

// File: tb/tb_pe16_ctrl.sv
// Bench for pe16_ctrl: directed frames, drains, error cases and a random
// phase, all checked against a cycle-level behavioural model.
module tb_pe16_ctrl;

   localparam int IDX_W = 6;
   localparam int SPAN  = 16;
   localparam int FRAME = 1 << IDX_W;

   logic clk = 1'b0;
   logic rst, in_valid, in_first, flush;
   logic s0, s1, w_en, r_en, out_valid, out_first, busy, err;

   int checks = 0;
   int failures = 0;

   // model state
   bit m_known = 0;
   int m_idx = 0;
   bit m_primed = 0;
   int m_drain = 0;      // remaining drain cycles
   bit m_err = 0;
   bit m_wen = 0;
   bit m_ov = 0, m_of = 0;   // visible output tag
   bit m_pv = 0, m_pf = 0;   // tag one cycle behind

   pe16_ctrl #(.IDX_W(IDX_W), .SPAN(SPAN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first),
      .flush(flush), .s0(s0), .s1(s1), .w_en(w_en), .r_en(r_en),
      .out_valid(out_valid), .out_first(out_first), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
   task automatic step(input bit r, input bit iv, input bit fi, input bit fl);
      int nxt, q;
      bit es0, es1, mbusy, tv, tf;
      @(negedge clk);
      rst = r; in_valid = iv; in_first = fi; flush = fl;
      #1;
      mbusy = (m_drain > 0);
      if (m_known) begin
         chk("w_en", w_en, m_wen);
         chk("r_en", r_en, m_wen);
         chk("out_valid", out_valid, m_ov);
         chk("out_first", out_first, m_of);
         chk("err", err, m_err);
         chk("busy", busy, mbusy);
      end
      nxt = fi ? 0 : m_idx;
      q = nxt / SPAN;
      es0 = 0; es1 = 0;
      if (r) begin
      end else if (mbusy) es1 = 1;
      else if (iv) begin
         es0 = (q == 1) || (q == 3);
         es1 = (q == 0) && m_primed;
      end
      if (!(r && iv) && (m_known || r)) begin
         chk("s0", s0, es0);
         chk("s1", s1, es1);
      end
      if (r) begin
         m_known = 1; m_idx = 0; m_primed = 0; m_drain = 0; m_err = 0;
         m_wen = 0; m_ov = 0; m_of = 0; m_pv = 0; m_pf = 0;
         return;
      end
      if ((fl && (iv || mbusy || !m_primed)) || (iv && mbusy) ||
          (iv && !mbusy && fi && m_idx != 0))
         m_err = 1;
      m_wen = iv || mbusy;
      tv = 0; tf = 0;
      if (mbusy) tv = 1;
      else if (iv) begin
         tv = (nxt >= SPAN) || m_primed;
         tf = (nxt == SPAN);
      end
      m_ov = m_pv; m_of = m_pv && m_pf;
      m_pv = tv; m_pf = tf;
      if (mbusy) begin
         m_drain--;
         if (m_drain == 0) begin
            m_primed = 0;
            m_idx = 0;
         end
      end else if (iv) begin
         if (nxt == SPAN) m_primed = 1;
         m_idx = (nxt + 1) % FRAME;
      end else if (fl && m_primed) begin
         m_drain = SPAN;
      end
   endtask

   task automatic frame(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(0, 1, i == 0, 0);
         for (int g = 0; g < gap; g++) step(0, 0, 0, 0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; flush = 1'b0;
      // reset, two contiguous frames, drain
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      idle(2);
      frame(FRAME, 0);
      frame(FRAME, 0);
      step(0, 0, 0, 1);
      idle(22);
      // gapped frame after drain, then another frame and drain
      frame(FRAME, 3);
      frame(FRAME, 0);
      step(0, 0, 0, 1);
      idle(22);
      // flush before priming sets the error flag
      step(1, 0, 0, 0);
      frame(10, 0);
      step(0, 0, 0, 1);
      idle(4);
      // in_valid and flush during a drain
      step(1, 0, 0, 0);
      frame(FRAME, 0);
      step(0, 0, 0, 1);
      idle(3);
      step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      step(0, 0, 0, 1);
      idle(20);
      // reset in the middle of a frame, then a clean frame
      step(1, 0, 0, 0);
      frame(41, 0);
      step(1, 0, 0, 0);
      frame(FRAME, 0);
      frame(FRAME, 0);
      // mid-frame resync via in_first
      frame(20, 0);
      frame(FRAME, 0);
      // randomized traffic
      step(1, 0, 0, 0);
      for (int i = 0; i < 1500; i++) begin
         int p;
         bit iv, fi, fl;
         p  = $urandom_range(99, 0);
         iv = (p < 60);
         fi = iv && ($urandom_range(99, 0) < 4);
         fl = ($urandom_range(99, 0) < 3);
         if (i % 400 == 0) step(1, 0, 0, 0);
         else if (i % 400 == 1) step(0, 1, 1, 0);
         else step(0, iv, fi, fl);
      end
      idle(20);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
